mp_add_seq: RTL
===============

Name: mp_add_seq

Overview:
- Multi-cycle, multi-precision add/subtract sequencer.
- Computes a W-bit sum (W = N*K) by time-sharing one N-bit ripple-carry adder slice over K cycles. The carry is held in a register between slices.
- Sits between a requester and a consumer, with a valid/ready handshake on both sides.
- Trades area for latency on wide operands.

Parameters:
- N, 4, width of the single ripple-carry adder slice (bits per cycle).
- K, 4, number of slices per operation. K >= 1. Total operand width W = N*K.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  requester has an operation on a/b/cin/sub.
- in_ready  out  1  block can accept an operation.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in, used only when sub=0.
- sub  in  1  1 = compute a - b; 0 = compute a + b + cin.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result.
- cout  out  1  final carry out. For sub, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1.
  - out_valid = 0; sum = 0; cout = 0; ovf = 0.
  - All operand registers, slice index and carry register are cleared.
  - Reset asserted mid-operation abandons the operation; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready at a clock edge, capture the operation:
    - Register a.
    - Register b_eff = sub ? ~b : b.
    - Carry register = sub ? 1 : cin.
    - Slice index = 0. Go to RUN.
  - No capture when in_valid = 0.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, the slice adds a[idx*N +: N] + b_eff[idx*N +: N] + carry.
  - At the edge: store the slice sum into sum[idx*N +: N]; carry <= slice carry-out; idx <= idx + 1.
  - When idx == K-1, the final carry goes to cout and the state goes to DONE.
  - ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), registered when entering DONE.
  - Inputs are ignored in RUN.
- DONE:
  - out_valid = 1, in_ready = 0.
  - sum, cout and ovf are held stable until out_ready = 1.
  - On out_valid && out_ready, go to IDLE. out_valid drops the next cycle.
  - sum, cout and ovf keep their last values in IDLE; they are valid only while out_valid = 1.
- Latency:
  - out_valid rises exactly K clock edges after the accepting edge.
  - Minimum issue interval is K+2 cycles (accept, K RUN cycles, DONE handshake, back in IDLE).
  - There is no accept in the same cycle as the DONE handshake.
- Width and arithmetic:
  - All arithmetic is modulo 2^W. No saturation.
  - K=1 degenerates to one RUN cycle.
  - Operands captured at accept are unaffected by later changes on a/b/cin/sub.
- Simultaneous events: only one of in_valid or out_ready is meaningful per state; the other input is a don't-care.

Decomposition:
- Shared package/include holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2-based index width for K.
- One sub-module: the existing rca_nbit, instantiated once with parameter n = N. Its ports map to the a slice, b_eff slice, carry register, slice sum and slice carry-out.
- FSM, registers and slice muxing live in mp_add_seq.
- Implementation choice: index muxing or shift-register operands (shift a and b_eff right by N each cycle, shift sum in from the top). Externally visible behaviour is identical either way.

Test Plan:
- Defaults N=4, K=4, W=16. Add 0xFFFF + 0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. out_valid rises exactly 4 edges after accept.
- Add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Add 0x1234 + 0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Subtract 0x0005 - 0x0007 (sub=1, cin=1 ignored) -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, sum/cout/ovf stable, in_ready=0. Toggle a/b during the hold -> no effect.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles -> all outputs 0 immediately (asynchronous), state IDLE. Next accepted op 0x0001+0x0001 -> sum=0x0002.
- Back-to-back: in_valid held high with out_ready=1 -> accepts every K+2 = 6 cycles. in_ready is low throughout RUN/DONE; no op is lost or duplicated over 5 consecutive ops.

Source files
------------

// File: rtl/mp_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_seq_pkg
//  Description : Shared definitions for the multi-precision add/subtract
//                sequencer: FSM state encoding and slice-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mp_add_seq_pkg;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the slice index register; at least one bit even when K == 1
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage : mp_add_seq_pkg
`default_nettype wire

// File: rtl/rca_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : rca_nbit
//  Description : n-bit ripple-carry adder slice (purely combinational).
//  Ports       : a, b  - n-bit addends
//                cin   - carry into bit 0
//                sum   - n-bit sum
//                cout  - carry out of bit n-1
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_bit
            assign sum[gi]        = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1]  = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[n];

endmodule : rca_nbit
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_seq
//  Description : Multi-cycle W-bit (W = N*K) add/subtract sequencer. One
//                N-bit ripple-carry slice is reused over K cycles with the
//                carry held in a register between slices.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                in_valid/in_ready    - request handshake
//                a, b, cin, sub       - operation (sub=1: a-b, else a+b+cin)
//                out_valid/out_ready  - result handshake
//                sum, cout, ovf       - result, carry (no-borrow), overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*K-1:0]   a,
    input  logic [N*K-1:0]   b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*K-1:0]   sum,
    output logic             cout,
    output logic             ovf
);

    localparam int W     = N * K;
    localparam int IDX_W = idx_width(K);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(K - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;       // b already inverted for subtract
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        w_base;
    logic [N-1:0]       w_a_slice;
    logic [N-1:0]       w_b_slice;
    logic [N-1:0]       w_slice_sum;
    logic               w_slice_cout;
    logic               w_last;

    assign w_base    = 32'(idx_q) * 32'(N);
    assign w_a_slice = a_q[w_base +: N];
    assign w_b_slice = b_q[w_base +: N];
    assign w_last    = (idx_q == c_last_idx);

    rca_nbit #(
        .n    (N)
    ) u_rca (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (carry_q),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b and force carry-in
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[w_base +: N] = w_slice_sum;
                carry_d            = w_slice_cout;
                idx_d              = idx_q + IDX_W'(1);
                if (w_last) begin
                    // Top slice holds the sign bits of both operands and result
                    cout_d  = w_slice_cout;
                    ovf_d   = (w_a_slice[N-1] == w_b_slice[N-1]) &&
                              (w_slice_sum[N-1] != w_a_slice[N-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule : mp_add_seq
`default_nettype wire
